// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the run-time configurable serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRun,
    StDone
  } state_e;

  // Width needed to hold a pattern length of 0..pat_w.
  function automatic int unsigned len_width(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_det_core.sv
// History shift register, fill counter and masked pattern compare.
module seq_det_core
  import seq_det_pkg::*;
#(
  parameter int unsigned PatW = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       shift_en_i,
  input  logic                       din_i,
  input  logic                       clr_i,
  input  logic                       fill_clr_i,
  input  logic [len_width(PatW)-1:0] len_i,
  input  logic [PatW-1:0]            pattern_i,
  output logic                       match_o
);

  localparam int unsigned LenW = len_width(PatW);

  logic [PatW-1:0] hist_q, hist_d, hist_nxt, mask;
  logic [LenW-1:0] fill_q, fill_d, fill_nxt;

  assign hist_nxt = (hist_q << 1) | PatW'(din_i);
  assign fill_nxt = (fill_q == LenW'(PatW)) ? fill_q : fill_q + LenW'(1);
  assign mask     = ~({PatW{1'b1}} << len_i);

  // Compare against the history as it will be after this bit, so det can be registered.
  assign match_o = shift_en_i && (fill_nxt >= len_i) && (((hist_nxt ^ pattern_i) & mask) == '0);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en_i) begin
      hist_d = hist_nxt;
      fill_d = fill_clr_i ? '0 : fill_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Serial pattern detector controller: config handshake, FSM, match counter.
// Optional idle-bit timeout built when SEQ_DET_CTRL_TIMEOUT_EN is defined.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W       = 8,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [PAT_W-1:0]            cfg_pattern,
  input  logic [len_width(PAT_W)-1:0] cfg_len,
  input  logic                        cfg_overlap,
  input  logic [CNT_W-1:0]            cfg_threshold,
  output logic                        cfg_err,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        din_valid,
  input  logic                        din,
  output logic                        det,
  output logic [CNT_W-1:0]            match_count,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout
);

  localparam int unsigned LenW = len_width(PAT_W);

  typedef struct packed {
    logic [PAT_W-1:0] pattern;
    logic [LenW-1:0]  len;
    logic             overlap;
    logic [CNT_W-1:0] threshold;
  } cfg_t;

  state_e           state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  logic             det_q, det_d, cfg_err_q, cfg_err_d;
  logic             cfg_fire, cfg_ok, shift_en, core_clr, fill_clr, match, to_hit;

  assign cfg_ready = (state_q != StRun);
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign cfg_ok    = cfg_fire & (cfg_len != '0);
  assign shift_en  = (state_q == StRun) & din_valid;
  assign count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);

  seq_det_core #(
    .PatW (PAT_W)
  ) u_core (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .shift_en_i (shift_en),
    .din_i      (din),
    .clr_i      (core_clr),
    .fill_clr_i (fill_clr),
    .len_i      (cfg_q.len),
    .pattern_i  (cfg_q.pattern),
    .match_o    (match)
  );

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    count_d   = count_q;
    det_d     = 1'b0;
    cfg_err_d = cfg_fire & (cfg_len == '0);
    core_clr  = 1'b0;
    fill_clr  = 1'b0;
    if (cfg_ok) begin
      // A config accepted this cycle wins over start.
      cfg_d.pattern   = cfg_pattern;
      cfg_d.len       = (cfg_len > LenW'(PAT_W)) ? LenW'(PAT_W) : cfg_len;
      cfg_d.overlap   = cfg_overlap;
      cfg_d.threshold = cfg_threshold;
      state_d         = StArmed;
    end else begin
      unique case (state_q)
        StArmed, StDone: begin
          if (start) begin
            count_d  = '0;
            core_clr = 1'b1;
            state_d  = StRun;
          end
        end
        StRun: begin
          if (match) begin
            det_d    = 1'b1;
            count_d  = count_inc;
            fill_clr = ~cfg_q.overlap;
          end
          if (match && (cfg_q.threshold != '0) && (count_inc >= cfg_q.threshold)) begin
            state_d = StDone;
          end else if (to_hit) begin
            state_d = StDone;
          end else if (stop) begin
            state_d = StArmed;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cfg_q     <= '0;
      count_q   <= '0;
      det_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      count_q   <= count_d;
      det_q     <= det_d;
      cfg_err_q <= cfg_err_d;
    end
  end

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);

  logic [ToW-1:0] to_cnt_q, to_cnt_d, to_cnt_inc;
  logic           timeout_q;

  assign to_cnt_inc = to_cnt_q + ToW'(1);
  // A match on the limit bit wins over the timeout.
  assign to_hit     = shift_en & ~match & (to_cnt_inc == ToW'(TIMEOUT_CYC));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (core_clr || match || to_hit) begin
      to_cnt_d = '0;
    end else if (shift_en) begin
      to_cnt_d = to_cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= to_hit;
    end
  end

  assign timeout = timeout_q;
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign det         = det_q;
  assign cfg_err     = cfg_err_q;
  assign match_count = count_q;
  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl; expected det values queued per driven bit.
module tb_seq_det_ctrl;

  localparam int unsigned PAT_W       = 8;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned TIMEOUT_CYC = 8;
  localparam int unsigned LenW        = $clog2(PAT_W + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_valid, cfg_ready, cfg_overlap, cfg_err;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LenW-1:0]  cfg_len;
  logic [CNT_W-1:0] cfg_threshold, match_count;
  logic             start, stop, din_valid, din, det, busy, done, timeout;

  int checks = 0;
  int errors = 0;
  bit exp_det_q[$];

  always #5 clk = ~clk;

  seq_det_ctrl #(
    .PAT_W       (PAT_W),
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_pattern   (cfg_pattern),
    .cfg_len       (cfg_len),
    .cfg_overlap   (cfg_overlap),
    .cfg_threshold (cfg_threshold),
    .cfg_err       (cfg_err),
    .start         (start),
    .stop          (stop),
    .din_valid     (din_valid),
    .din           (din),
    .det           (det),
    .match_count   (match_count),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [PAT_W-1:0] pat, input logic [LenW-1:0] len,
                          input logic ovl, input logic [CNT_W-1:0] thr);
    cfg_valid     = 1'b1;
    cfg_pattern   = pat;
    cfg_len       = len;
    cfg_overlap   = ovl;
    cfg_threshold = thr;
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
  endtask

  task automatic send_bit(input logic b, input bit e);
    bit e_pop;
    exp_det_q.push_back(e);
    din_valid = 1'b1;
    din       = b;
    cycle();
    din_valid = 1'b0;
    din       = 1'b0;
    e_pop     = exp_det_q.pop_front();
    chk("det", det, e_pop);
  endtask

  task automatic send_gap();
    bit e_pop;
    exp_det_q.push_back(1'b0);
    din_valid = 1'b0;
    din       = 1'b1;
    cycle();
    din   = 1'b0;
    e_pop = exp_det_q.pop_front();
    chk("det_gap", det, e_pop);
  endtask

  // First bit sent is bit n-1 of bits; dets follows the same order.
  task automatic send_stream(input logic [31:0] bits, input int n, input logic [31:0] dets);
    for (int i = 0; i < n; i++) send_bit(bits[n-1-i], dets[n-1-i]);
  endtask

  initial begin
    rst_n = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_threshold = '0; start = 1'b0; stop = 1'b0; din_valid = 1'b0; din = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) cycle();
    chk("rst_det", det, 0);
    chk("rst_count", match_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    cycle();
    pulse_start();
    chk("idle_ignores_start", busy, 0);

    // Overlapping 1011
    send_cfg(8'b1011, 4, 1'b1, 0);
    chk("armed_busy", busy, 0);
    pulse_start();
    chk("run_busy", busy, 1);
    send_stream(32'b1011011, 7, 32'b0001001);
    chk("t1_count", match_count, 2);
    chk("t1_busy", busy, 1);

    // Non-overlapping 1011
    pulse_stop();
    chk("stop_busy", busy, 0);
    chk("stop_keeps_count", match_count, 2);
    send_cfg(8'b1011, 4, 1'b0, 0);
    pulse_start();
    chk("start_clears_count", match_count, 0);
    send_stream(32'b10110111011, 11, 32'b00010000001);
    chk("t2_count", match_count, 2);

    // Threshold 2
    pulse_stop();
    send_cfg(8'b1011, 4, 1'b1, 2);
    pulse_start();
    send_stream(32'b1011011, 7, 32'b0001001);
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 0);
    chk("t3_count", match_count, 2);
    send_stream(32'b1011, 4, 32'b0000);
    chk("t3_frozen", match_count, 2);
    pulse_start();
    chk("t3_restart_busy", busy, 1);
    chk("t3_restart_count", match_count, 0);

    // Config offered during RUN is not taken
    chk("run_ready", cfg_ready, 0);
    send_cfg(8'hFF, 4, 1'b1, 0);
    chk("run_cfg_busy", busy, 1);
    chk("run_cfg_err", cfg_err, 0);
    send_stream(32'b1011, 4, 32'b0001);
    chk("t4_count", match_count, 1);

    // Zero length is rejected
    pulse_stop();
    send_cfg(8'hFF, 0, 1'b0, 0);
    chk("len0_err", cfg_err, 1);
    cycle();
    chk("len0_err_pulse", cfg_err, 0);
    chk("len0_busy", busy, 0);
    chk("len0_done", done, 0);
    pulse_start();
    send_stream(32'b1011, 4, 32'b0001);
    chk("len0_cfg_kept", done, 0);

    // Threshold reached together with stop: DONE wins
    send_stream(32'b101, 3, 32'b000);
    exp_det_q.push_back(1'b1);
    din_valid = 1'b1; din = 1'b1; stop = 1'b1;
    cycle();
    din_valid = 1'b0; din = 1'b0; stop = 1'b0;
    begin
      bit e_pop;
      e_pop = exp_det_q.pop_front();
      chk("thr_stop_det", det, e_pop);
    end
    chk("thr_stop_done", done, 1);
    chk("thr_stop_count", match_count, 2);

    // Length 12 clamps to 8
    send_cfg(8'b11001010, 12, 1'b0, 0);
    pulse_start();
    send_stream(32'b11001010, 8, 32'b00000001);
    chk("clamp_count", match_count, 1);

    // Counter saturation with a 1-bit pattern
    pulse_stop();
    send_cfg(8'b1, 1, 1'b1, 0);
    pulse_start();
    for (int i = 0; i < 260; i++) send_bit(1'b1, 1'b1);
    chk("sat_count", match_count, 255);

    // Reset mid-pattern
    pulse_stop();
    send_cfg(8'b1011, 4, 1'b1, 0);
    pulse_start();
    send_stream(32'b101, 3, 32'b000);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_det", det, 0);
    chk("mid_rst_count", match_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cfg_ready, 1);
    cycle();
    rst_n = 1'b1;
    send_bit(1'b1, 1'b0);
    chk("post_rst_count", match_count, 0);

    // Reset right after a matching bit drops the det
    send_cfg(8'b1011, 4, 1'b1, 0);
    pulse_start();
    send_stream(32'b1011, 4, 32'b0001);
    rst_n = 1'b0;
    #1;
    chk("rst_kills_det", det, 0);
    cycle();
    rst_n = 1'b1;
    cycle();

    // Idle-bit timeout on an all-zero stream with gaps
    send_cfg(8'b1011, 4, 1'b1, 0);
    pulse_start();
    for (int i = 0; i < TIMEOUT_CYC; i++) begin
      send_gap();
      send_bit(1'b0, 1'b0);
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
      chk("timeout_pulse", timeout, (i == TIMEOUT_CYC - 1) ? 1 : 0);
`else
      chk("timeout_off", timeout, 0);
`endif
    end
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    chk("timeout_done", done, 1);
    cycle();
    chk("timeout_one_cycle", timeout, 0);
`else
    chk("no_timeout_busy", busy, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
